// File: rtl/tile_sequencer_if.sv
// Instruction, load/compute control and result-row handshake bundle for tile_sequencer.
// Latency: none (wiring only). Backpressure: out_ready from the sink, rd_nxt_inst pops the instruction buffer.
// master = sequencer side, slave = instruction buffer / array / result sink side.
interface tile_sequencer_if #(
    parameter int ARRAY_N = 4
);
    localparam int IW = $clog2(ARRAY_N);

    logic          instr_valid;
    logic          start;
    logic          last;
    logic          out_ready;
    logic          rd_nxt_inst;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic          comp_en;
    logic          out_wr_en;
    logic [IW-1:0] out_row;
    logic          busy;
    logic          done;

    modport master (
        input  instr_valid, start, last, out_ready,
        output rd_nxt_inst, ld_en, ld_idx, comp_en, out_wr_en, out_row, busy, done
    );

    modport slave (
        output instr_valid, start, last, out_ready,
        input  rd_nxt_inst, ld_en, ld_idx, comp_en, out_wr_en, out_row, busy, done
    );
endinterface

// File: rtl/tile_sequencer.sv
// Sequences one systolic tile: ARRAY_N load cycles, 3*ARRAY_N-2 compute cycles, ARRAY_N drained rows, then pop.
// Latency: 20 cycles from start acceptance to done at ARRAY_N=4 with the sink always ready.
// Backpressure: DRAIN holds row index and state while out_ready is low. Optional TILE_SEQ_PERF_CNT_EN adds tile_cycles.
module tile_sequencer #(
    parameter int ARRAY_N = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    tile_sequencer_if.master       bus
`ifdef TILE_SEQ_PERF_CNT_EN
    ,
    output logic [31:0]            tile_cycles
`endif
);
    localparam int IW = $clog2(ARRAY_N);
    localparam int CW = $clog2(3 * ARRAY_N);

    localparam logic [CW-1:0] ROW_LAST = CW'(ARRAY_N - 1);
    localparam logic [CW-1:0] CMP_LAST = CW'(3 * ARRAY_N - 3);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_COMPUTE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_NEXT    = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          last_q, last_d;

    logic          rd_nxt_inst;
    logic          ld_en;
    logic [IW-1:0] ld_idx;
    logic          comp_en;
    logic          out_wr_en;
    logic [IW-1:0] out_row;
    logic          busy;
    logic          done;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        last_d      = last_q;
        rd_nxt_inst = 1'b0;
        ld_en       = 1'b0;
        ld_idx      = '0;
        comp_en     = 1'b0;
        out_wr_en   = 1'b0;
        out_row     = '0;
        busy        = (state_q != ST_IDLE);
        done        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                // rst gate keeps the NOP pop quiet while reset is held with an instruction pending
                if (bus.instr_valid && rst) begin
                    if (bus.start) begin
                        state_d = ST_LOAD;
                        last_d  = bus.last;
                        cnt_d   = '0;
                    end else begin
                        rd_nxt_inst = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                ld_en  = 1'b1;
                ld_idx = cnt_q[IW-1:0];
                if (cnt_q == ROW_LAST) begin
                    state_d = ST_COMPUTE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_COMPUTE: begin
                comp_en = 1'b1;
                if (cnt_q == CMP_LAST) begin
                    state_d = ST_DRAIN;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DRAIN: begin
                out_row = cnt_q[IW-1:0];
                if (bus.out_ready) begin
                    out_wr_en = 1'b1;
                    if (cnt_q == ROW_LAST) begin
                        state_d = ST_NEXT;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_NEXT: begin
                rd_nxt_inst = 1'b1;
                state_d     = last_q ? ST_DONE : ST_IDLE;
            end
            ST_DONE: begin
                done    = 1'b1;
                last_d  = 1'b0;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
                last_d  = 1'b0;
            end
        endcase
    end

    assign bus.rd_nxt_inst = rd_nxt_inst;
    assign bus.ld_en       = ld_en;
    assign bus.ld_idx      = ld_idx;
    assign bus.comp_en     = comp_en;
    assign bus.out_wr_en   = out_wr_en;
    assign bus.out_row     = out_row;
    assign bus.busy        = busy;
    assign bus.done        = done;

`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] tc_q, tc_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tc_q <= '0;
        end else begin
            tc_q <= tc_d;
        end
    end

    // Counts LOAD entry through the NEXT cycle; DONE and IDLE leave the value visible.
    always_comb begin
        tc_d = tc_q;
        if (state_q == ST_IDLE && state_d == ST_LOAD) begin
            tc_d = '0;
        end else if ((state_q == ST_LOAD) || (state_q == ST_COMPUTE) ||
                     (state_q == ST_DRAIN) || (state_q == ST_NEXT)) begin
            if (tc_q != 32'hFFFF_FFFF) begin
                tc_d = tc_q + 32'd1;
            end
        end
    end

    assign tile_cycles = tc_q;
`endif
endmodule

// File: tb/tb_tile_sequencer.sv
// Directed bench for tile_sequencer at ARRAY_N=4: reset, single tile, back-to-back, NOP, drain stall, mid-tile reset.
module tb_tile_sequencer;
    localparam int N = 4;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    tile_sequencer_if #(.ARRAY_N(N)) bus ();

`ifdef TILE_SEQ_PERF_CNT_EN
    logic [31:0] tile_cycles;
`endif

    tile_sequencer #(.ARRAY_N(N)) dut (
        .clk         (clk),
        .rst         (rst),
        .bus         (bus)
`ifdef TILE_SEQ_PERF_CNT_EN
        ,
        .tile_cycles (tile_cycles)
`endif
    );

    int checks   = 0;
    int failures = 0;

    int n_ld, n_cmp, n_wr, n_rd, n_done, done_cyc, last_cyc;
    int seq_bad, onehot_bad, stall_bad, stall_seen;
    bit tmo;

    // Issues one instruction from IDLE and observes until the sequencer is idle again.
    task automatic run_tile(input logic s, input logic l, input int stall_len);
        int left;
        left = stall_len;
        n_ld = 0; n_cmp = 0; n_wr = 0; n_rd = 0; n_done = 0; done_cyc = -1; last_cyc = -1;
        seq_bad = 0; onehot_bad = 0; stall_bad = 0; stall_seen = 0;
        bus.instr_valid = 1'b1; bus.start = s; bus.last = l; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.start = 1'b0; bus.last = 1'b0;
        tmo = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            bus.out_ready = 1'b1;
            if (n_cmp == 10 && n_wr == 2 && left > 0) begin
                bus.out_ready = 1'b0;
                left--;
            end
            #1;
            if (!bus.busy) begin
                tmo = 1'b0;
                last_cyc = c;
                break;
            end
            if (!bus.out_ready) begin
                stall_seen++;
                if (bus.out_row != 2'd2 || bus.out_wr_en || bus.comp_en) stall_bad++;
            end
            if (32'(bus.ld_en) + 32'(bus.comp_en) + 32'(bus.out_wr_en) > 1) onehot_bad++;
            if (bus.ld_en) begin
                if (bus.ld_idx != 2'(n_ld)) seq_bad++;
                n_ld++;
            end
            if (bus.comp_en) n_cmp++;
            if (bus.out_wr_en) begin
                if (bus.out_row != 2'(n_wr)) seq_bad++;
                n_wr++;
            end
            if (bus.rd_nxt_inst) n_rd++;
            if (bus.done) begin
                n_done++;
                done_cyc = c;
            end
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic test_reset;
        bus.instr_valid = 1'b1; bus.start = 1'b0; bus.last = 1'b1; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
        checks++; if (bus.rd_nxt_inst !== 1'b0) begin failures++; $display("FAIL reset_rd got=%b exp=0", bus.rd_nxt_inst); end
        checks++; if ({bus.ld_en, bus.comp_en, bus.out_wr_en, bus.done} !== 4'b0) begin failures++; $display("FAIL reset_en got=%b exp=0000", {bus.ld_en, bus.comp_en, bus.out_wr_en, bus.done}); end
        checks++; if ({bus.ld_idx, bus.out_row} !== 4'b0) begin failures++; $display("FAIL reset_idx got=%b exp=0000", {bus.ld_idx, bus.out_row}); end
`ifdef TILE_SEQ_PERF_CNT_EN
        checks++; if (tile_cycles !== 32'd0) begin failures++; $display("FAIL reset_tc got=%0d exp=0", tile_cycles); end
`endif
        bus.instr_valid = 1'b0; bus.start = 1'b0; bus.last = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_single_tile;
        run_tile(1'b1, 1'b1, 0);
        checks++; if (tmo) begin failures++; $display("FAIL single_timeout got=timeout exp=idle"); end
        checks++; if (n_ld != 4) begin failures++; $display("FAIL single_ld got=%0d exp=4", n_ld); end
        checks++; if (n_cmp != 10) begin failures++; $display("FAIL single_cmp got=%0d exp=10", n_cmp); end
        checks++; if (n_wr != 4) begin failures++; $display("FAIL single_wr got=%0d exp=4", n_wr); end
        checks++; if (seq_bad != 0) begin failures++; $display("FAIL single_idx_seq got=%0d exp=0", seq_bad); end
        checks++; if (onehot_bad != 0) begin failures++; $display("FAIL single_onehot got=%0d exp=0", onehot_bad); end
        checks++; if (n_rd != 1) begin failures++; $display("FAIL single_rd got=%0d exp=1", n_rd); end
        checks++; if (n_done != 1) begin failures++; $display("FAIL single_done got=%0d exp=1", n_done); end
        checks++; if (done_cyc != 20) begin failures++; $display("FAIL single_latency got=%0d exp=20", done_cyc); end
        checks++; if (last_cyc != 21) begin failures++; $display("FAIL single_idle got=%0d exp=21", last_cyc); end
`ifdef TILE_SEQ_PERF_CNT_EN
        checks++; if (tile_cycles !== 32'd19) begin failures++; $display("FAIL single_tc got=%0d exp=19", tile_cycles); end
`endif
    endtask

    task automatic test_back_to_back;
        run_tile(1'b1, 1'b0, 0);
        checks++; if (n_wr != 4 || n_rd != 1) begin failures++; $display("FAIL b2b_first_tile got=wr%0d/rd%0d exp=wr4/rd1", n_wr, n_rd); end
        checks++; if (n_done != 0) begin failures++; $display("FAIL b2b_first_done got=%0d exp=0", n_done); end
        checks++; if (last_cyc != 20) begin failures++; $display("FAIL b2b_first_idle got=%0d exp=20", last_cyc); end
        run_tile(1'b1, 1'b1, 0);
        checks++; if (n_ld != 4 || n_cmp != 10 || n_wr != 4) begin failures++; $display("FAIL b2b_second_tile got=%0d/%0d/%0d exp=4/10/4", n_ld, n_cmp, n_wr); end
        checks++; if (n_rd != 1 || n_done != 1) begin failures++; $display("FAIL b2b_second_end got=rd%0d/done%0d exp=rd1/done1", n_rd, n_done); end
    endtask

    task automatic test_nop;
        bus.instr_valid = 1'b0; bus.start = 1'b1; bus.last = 1'b1;
        #1;
        checks++; if (bus.rd_nxt_inst !== 1'b0 || bus.busy !== 1'b0) begin failures++; $display("FAIL invalid_ignored got=rd%b/busy%b exp=0/0", bus.rd_nxt_inst, bus.busy); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL invalid_busy got=%b exp=0", bus.busy); end
        bus.instr_valid = 1'b1; bus.start = 1'b0; bus.last = 1'b0;
        #1;
        checks++; if (bus.rd_nxt_inst !== 1'b1) begin failures++; $display("FAIL nop_rd got=%b exp=1", bus.rd_nxt_inst); end
        checks++; if ({bus.busy, bus.ld_en, bus.comp_en, bus.out_wr_en} !== 4'b0) begin failures++; $display("FAIL nop_quiet got=%b exp=0000", {bus.busy, bus.ld_en, bus.comp_en, bus.out_wr_en}); end
        @(posedge clk); #1;
        bus.instr_valid = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.rd_nxt_inst, bus.ld_en} !== 3'b0) begin failures++; $display("FAIL nop_after got=%b exp=000", {bus.busy, bus.rd_nxt_inst, bus.ld_en}); end
        @(posedge clk); #1;
    endtask

    task automatic test_drain_stall;
        run_tile(1'b1, 1'b1, 5);
        checks++; if (stall_seen != 5) begin failures++; $display("FAIL stall_cycles got=%0d exp=5", stall_seen); end
        checks++; if (stall_bad != 0) begin failures++; $display("FAIL stall_hold got=%0d exp=0", stall_bad); end
        checks++; if (n_wr != 4 || seq_bad != 0) begin failures++; $display("FAIL stall_rows got=wr%0d/bad%0d exp=wr4/bad0", n_wr, seq_bad); end
        checks++; if (done_cyc != 25) begin failures++; $display("FAIL stall_latency got=%0d exp=25", done_cyc); end
`ifdef TILE_SEQ_PERF_CNT_EN
        checks++; if (tile_cycles !== 32'd24) begin failures++; $display("FAIL stall_tc got=%0d exp=24", tile_cycles); end
`endif
    endtask

    task automatic test_reset_mid_tile;
        int rd_seen;
        int done_seen;
        bit fin;
        bus.instr_valid = 1'b1; bus.start = 1'b1; bus.last = 1'b1; bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.start = 1'b0; bus.last = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (bus.comp_en !== 1'b1) begin failures++; $display("FAIL midrst_in_compute got=%b exp=1", bus.comp_en); end
        bus.instr_valid = 1'b1; bus.start = 1'b1; bus.last = 1'b1;
        #1;
        rst = 1'b0;
        #1;
        checks++; if ({bus.busy, bus.comp_en, bus.ld_en, bus.out_wr_en, bus.rd_nxt_inst, bus.done} !== 6'b0) begin failures++; $display("FAIL midrst_async got=%b exp=000000", {bus.busy, bus.comp_en, bus.ld_en, bus.out_wr_en, bus.rd_nxt_inst, bus.done}); end
        @(posedge clk); #1;
        checks++; if (bus.busy !== 1'b0 || bus.rd_nxt_inst !== 1'b0) begin failures++; $display("FAIL midrst_held got=busy%b/rd%b exp=0/0", bus.busy, bus.rd_nxt_inst); end
        rst = 1'b1;
        @(posedge clk); #1;
        bus.instr_valid = 1'b0; bus.start = 1'b0; bus.last = 1'b0;
        checks++; if (bus.ld_en !== 1'b1 || bus.ld_idx !== 2'd0) begin failures++; $display("FAIL midrst_restart got=ld%b/idx%0d exp=1/0", bus.ld_en, bus.ld_idx); end
        rd_seen = 0; done_seen = 0; fin = 1'b0;
        for (int c = 0; c < 100; c++) begin
            if (!bus.busy) begin
                fin = 1'b1;
                break;
            end
            if (bus.rd_nxt_inst) rd_seen++;
            if (bus.done) done_seen++;
            @(posedge clk); #1;
        end
        checks++; if (!fin) begin failures++; $display("FAIL midrst_timeout got=timeout exp=idle"); end
        checks++; if (rd_seen != 1 || done_seen != 1) begin failures++; $display("FAIL midrst_pops got=rd%0d/done%0d exp=rd1/done1", rd_seen, done_seen); end
    endtask

    initial begin
        bus.instr_valid = 1'b0;
        bus.start       = 1'b0;
        bus.last        = 1'b0;
        bus.out_ready   = 1'b1;
        test_reset();
        test_single_tile();
        test_back_to_back();
        test_nop();
        test_drain_stall();
        test_reset_mid_tile();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
